// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared encodings for the multicycle MIPS fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'b000,
    PC_JUMP   = 3'b001,
    PC_REG    = 3'b010,
    PC_BRANCH = 3'b011,
    PC_HOLD   = 3'b100
  } pc_ctrl_e;

  localparam logic [1:0] RSEL_ILLEGAL = 2'b00;
  localparam logic [1:0] RSEL_JUMP    = 2'b01;
  localparam logic [1:0] RSEL_REG     = 2'b10;
  localparam logic [1:0] RSEL_BRANCH  = 2'b11;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ERROR = 3'd4
  } fetch_state_e;

  // The illegal select falls back to a plain jump.
  function automatic pc_ctrl_e redirect_pc_ctrl(input logic [1:0] sel);
    pc_ctrl_e r;
    case (sel)
      RSEL_REG:    r = PC_REG;
      RSEL_BRANCH: r = PC_BRANCH;
      default:     r = PC_JUMP;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_controller_if.sv
// ============================================================================
// Module      : fetch_controller_if
// Description : Instruction-memory request/response bus of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output req_valid, output addr, input req_ready, input rsp_valid, input rsp_data);
  modport slave  (input req_valid, input addr, output req_ready, output rsp_valid, output rsp_data);
endinterface

`default_nettype wire

// File: rtl/fetch_watchdog.sv
// ============================================================================
// Module      : fetch_watchdog
// Description : Cycle counter flagging an overdue instruction-memory response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic start,
  input  wire logic clear,
  output logic      expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_count;
  logic          r_running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_running <= 1'b0;
    end else if (start) begin
      r_count   <= '0;
      r_running <= 1'b1;
    end else if (clear) begin
      r_count   <= '0;
      r_running <= 1'b0;
    end else if (r_running) begin
      r_count   <= r_count + CW'(1);
    end
  end

  // Fires during the last allowed waiting cycle so the error registers on its edge.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_wd_off
      assign expired = 1'b0;
    end else begin : g_wd_on
      assign expired = r_running && (r_count == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// Module      : fetch_controller
// Description : Single-outstanding fetch sequencer with PC redirect handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic [31:0]        pc,
  output logic [2:0]              pc_control,
  fetch_controller_if.master      imem,
  output logic                    instr_valid,
  input  wire logic               instr_ready,
  output logic [31:0]             instr,
  output logic [31:0]             instr_pc,
  input  wire logic               redirect_valid,
  input  wire logic [1:0]         redirect_sel,
  output logic                    redirect_ack,
  output logic                    fetch_error,
  output logic [CNT_W-1:0]        fetch_count
);

  fetch_state_e     r_state;
  fetch_state_e     w_next;
  logic [31:0]      r_instr;
  logic [31:0]      r_instr_pc;
  logic [CNT_W-1:0] r_fetch_count;
  logic             r_fetch_error;
  logic             w_expired;
  logic             w_wait_now;
  logic             w_wait_next;
  logic             w_accept;
  logic             w_capture;
  logic             w_deliver;

  assign imem.addr   = pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_count = r_fetch_count;
  assign fetch_error = r_fetch_error;

  assign w_accept  = (r_state == ST_REQ)  && !redirect_valid && imem.req_ready;
  assign w_capture = (r_state == ST_WAIT) && !redirect_valid && imem.rsp_valid;
  assign w_deliver = (r_state == ST_HOLD) && !redirect_valid && instr_ready;

  assign w_wait_now  = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
  assign w_wait_next = (w_next == ST_WAIT) || (w_next == ST_DRAIN);

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_wait_next && (w_next != r_state)),
    .clear  (w_wait_now && !w_wait_next),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_REQ;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_fetch_count <= '0;
      r_fetch_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept)           r_instr_pc    <= pc;
      if (w_capture)          r_instr       <= imem.rsp_data;
      if (w_deliver)          r_fetch_count <= r_fetch_count + CNT_W'(1);
      if (w_next == ST_ERROR) r_fetch_error <= 1'b1;
    end
  end

  // A real response or redirect in the final waiting cycle wins over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_REQ: begin
        if (!redirect_valid && imem.req_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid)      w_next = imem.rsp_valid ? ST_REQ : ST_DRAIN;
        else if (imem.rsp_valid) w_next = ST_HOLD;
        else if (w_expired)      w_next = ST_ERROR;
      end
      ST_DRAIN: begin
        if (imem.rsp_valid)      w_next = ST_REQ;
        else if (w_expired)      w_next = ST_ERROR;
      end
      ST_HOLD: begin
        if (redirect_valid || instr_ready) w_next = ST_REQ;
      end
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_ERROR;
    endcase
  end

  always_comb begin
    imem.req_valid = 1'b0;
    instr_valid    = 1'b0;
    redirect_ack   = 1'b0;
    pc_control     = PC_HOLD;
    if (rst_n) begin
      case (r_state)
        ST_REQ: begin
          imem.req_valid = !redirect_valid;
          if (redirect_valid) begin
            redirect_ack = 1'b1;
            pc_control   = redirect_pc_ctrl(redirect_sel);
          end else if (imem.req_ready) begin
            pc_control   = PC_SEQ;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            redirect_ack = 1'b1;
            pc_control   = redirect_pc_ctrl(redirect_sel);
          end
        end
        ST_HOLD: begin
          instr_valid = !redirect_valid;
          if (redirect_valid) begin
            redirect_ack = 1'b1;
            pc_control   = redirect_pc_ctrl(redirect_sel);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
// Module      : tb_fetch_controller
// Description : Directed vector bench for fetch_controller with a PC model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_controller;
  import core_pkg::*;

  localparam int          TO     = 4;
  localparam int          CW     = 4;
  localparam logic [31:0] JUMP_T = 32'h0000_0100;
  localparam logic [31:0] REG_T  = 32'h0000_0200;
  localparam logic [31:0] BR_T   = 32'h0000_0300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc;
  logic [2:0]    pc_control;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          redirect_valid;
  logic [1:0]    redirect_sel;
  logic          redirect_ack;
  logic          fetch_error;
  logic [CW-1:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0]   exp_pc;
  logic [CW-1:0] exp_count;

  fetch_controller_if imem();

  always #5 clk = ~clk;

  fetch_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .pc_control    (pc_control),
    .imem          (imem.master),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_sel  (redirect_sel),
    .redirect_ack  (redirect_ack),
    .fetch_error   (fetch_error),
    .fetch_count   (fetch_count)
  );

  // Program counter environment model driven by the controller's select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else begin
      case (pc_control)
        3'b000:  pc <= pc + 32'd4;
        3'b001:  pc <= JUMP_T;
        3'b010:  pc <= REG_T;
        3'b011:  pc <= BR_T;
        default: pc <= pc;
      endcase
    end
  end

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          stall;
    bit          redir;
    logic [1:0]  sel;
    logic [2:0]  exp_pcc;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] fpc;
    imem.req_ready = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
    #1;
    chk("req_valid", imem.req_valid, 1);
    chk("req_addr", imem.addr, exp_pc);
    chk("pcc_accept", pc_control, 3'b000);
    cyc();
    fpc = exp_pc;
    exp_pc = exp_pc + 32'd4;
    for (int i = 0; i < v.lat - 1; i++) begin
      #1;
      chk("wait_instr_valid", instr_valid, 0);
      chk("wait_req_valid", imem.req_valid, 0);
      cyc();
    end
    imem.rsp_valid = 1'b1; imem.rsp_data = v.data;
    cyc();
    imem.rsp_valid = 1'b0; imem.rsp_data = '0;
    for (int s = 0; s < v.stall; s++) begin
      #1;
      chk("stall_instr_valid", instr_valid, 1);
      chk("stall_instr", instr, v.data);
      chk("stall_instr_pc", instr_pc, fpc);
      chk("stall_pcc", pc_control, 3'b100);
      chk("stall_req_valid", imem.req_valid, 0);
      cyc();
    end
    if (v.redir) begin
      redirect_valid = 1'b1; redirect_sel = v.sel; instr_ready = 1'b1;
      #1;
      chk("hold_redir_instr_valid", instr_valid, 0);
      chk("hold_redir_ack", redirect_ack, 1);
      chk("hold_redir_pcc", pc_control, v.exp_pcc);
      cyc();
      redirect_valid = 1'b0; instr_ready = 1'b0;
      exp_pc = v.exp_target;
      #1;
      chk("hold_redir_count", fetch_count, exp_count);
      chk("hold_redir_pc", pc, exp_pc);
    end else begin
      instr_ready = 1'b1;
      #1;
      chk("hold_instr_valid", instr_valid, 1);
      chk("hold_instr", instr, v.data);
      chk("hold_instr_pc", instr_pc, fpc);
      chk("hold_pcc", pc_control, 3'b100);
      chk("hold_ack", redirect_ack, 0);
      cyc();
      instr_ready = 1'b0;
      exp_count = exp_count + 1'b1;
      #1;
      chk("deliver_count", fetch_count, exp_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t wv;
    vecs[0] = '{32'h2108_0001, 2, 0,  1'b0, 2'b00, 3'b100, 32'h0};
    vecs[1] = '{32'h8C09_0004, 1, 0,  1'b0, 2'b00, 3'b100, 32'h0};
    vecs[2] = '{32'hAC0A_0008, 3, 10, 1'b0, 2'b00, 3'b100, 32'h0};
    vecs[3] = '{32'h1000_FFFF, 1, 1,  1'b1, 2'b01, 3'b001, JUMP_T};
    vecs[4] = '{32'h0000_0008, 2, 0,  1'b1, 2'b10, 3'b010, REG_T};
    vecs[5] = '{32'h1109_0003, 1, 0,  1'b1, 2'b11, 3'b011, BR_T};
    vecs[6] = '{32'h0800_0040, 1, 2,  1'b1, 2'b00, 3'b001, JUMP_T};

    imem.req_ready = 1'b1; imem.rsp_valid = 1'b0; imem.rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_sel = 2'b00;
    exp_pc = 32'h0; exp_count = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_valid", imem.req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_ack", redirect_ack, 0);
    chk("rst_error", fetch_error, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_pcc", pc_control, 3'b100);
    cyc();
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Redirect while idle in REQ
    redirect_valid = 1'b1; redirect_sel = 2'b10; imem.req_ready = 1'b1;
    #1;
    chk("req_redir_req_valid", imem.req_valid, 0);
    chk("req_redir_ack", redirect_ack, 1);
    chk("req_redir_pcc", pc_control, 3'b010);
    cyc();
    redirect_valid = 1'b0; exp_pc = REG_T;
    #1;
    chk("req_redir_pc", pc, exp_pc);
    chk("req_redir_stay", imem.req_valid, 1);

    // Memory not ready plus a stale response in REQ
    imem.req_ready = 1'b0; imem.rsp_valid = 1'b1; imem.rsp_data = 32'hBAD0_0001;
    #1;
    chk("notready_req_valid", imem.req_valid, 1);
    chk("notready_pcc", pc_control, 3'b100);
    cyc();
    imem.rsp_valid = 1'b0;
    #1;
    chk("stale_instr_valid", instr_valid, 0);
    chk("stale_req_valid", imem.req_valid, 1);
    chk("stale_pc", pc, exp_pc);

    // Redirect in WAIT, response drained three cycles later
    imem.req_ready = 1'b1;
    #1;
    chk("drain_req_addr", imem.addr, exp_pc);
    cyc();
    exp_pc = exp_pc + 32'd4;
    redirect_valid = 1'b1; redirect_sel = 2'b11;
    #1;
    chk("wait_redir_ack", redirect_ack, 1);
    chk("wait_redir_pcc", pc_control, 3'b011);
    cyc();
    redirect_valid = 1'b1; redirect_sel = 2'b01; exp_pc = BR_T;
    #1;
    chk("drain_no_ack", redirect_ack, 0);
    chk("drain_pcc", pc_control, 3'b100);
    chk("drain_req_valid", imem.req_valid, 0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("drain2_instr_valid", instr_valid, 0);
    cyc();
    imem.rsp_valid = 1'b1; imem.rsp_data = 32'hDEAD_BEEF;
    #1;
    chk("drain3_instr_valid", instr_valid, 0);
    cyc();
    imem.rsp_valid = 1'b0;
    #1;
    chk("after_drain_req_valid", imem.req_valid, 1);
    chk("after_drain_addr", imem.addr, BR_T);
    chk("after_drain_instr_valid", instr_valid, 0);
    chk("after_drain_pcc", pc_control, 3'b000);

    // Redirect in WAIT with the response in the same cycle
    cyc();
    redirect_valid = 1'b1; redirect_sel = 2'b01;
    imem.rsp_valid = 1'b1; imem.rsp_data = 32'hDEAD_0002;
    #1;
    chk("wait_rsp_redir_ack", redirect_ack, 1);
    chk("wait_rsp_redir_pcc", pc_control, 3'b001);
    cyc();
    redirect_valid = 1'b0; imem.rsp_valid = 1'b0; imem.req_ready = 1'b0;
    exp_pc = JUMP_T;
    #1;
    chk("wait_rsp_back_req", imem.req_valid, 1);
    chk("wait_rsp_instr_valid", instr_valid, 0);
    chk("wait_rsp_addr", imem.addr, exp_pc);
    chk("wait_rsp_dropped", instr, 32'h0800_0040);

    // Counter wrap: 3 delivered so far, 13 more reach 16
    wv = '{32'h0000_0000, 1, 0, 1'b0, 2'b00, 3'b100, 32'h0};
    for (int i = 0; i < 13; i++) begin
      wv.data = 32'h2000_0000 + 32'(i);
      run_vec(wv);
    end
    chk("count_wrap", fetch_count, 0);

    // Watchdog: no response
    imem.req_ready = 1'b1;
    cyc();
    imem.req_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #2;
      chk("wd_error", fetch_error, (k == 4) ? 1 : 0);
    end
    redirect_valid = 1'b1; redirect_sel = 2'b11; imem.req_ready = 1'b1;
    imem.rsp_valid = 1'b1; instr_ready = 1'b1;
    #1;
    chk("err_req_valid", imem.req_valid, 0);
    chk("err_ack", redirect_ack, 0);
    chk("err_instr_valid", instr_valid, 0);
    chk("err_pcc", pc_control, 3'b100);
    cyc();
    #1;
    chk("err_sticky", fetch_error, 1);

    // Reset clears the error; a stale response after release is ignored
    rst_n = 1'b0;
    #1;
    chk("rst2_error", fetch_error, 0);
    chk("rst2_count", fetch_count, 0);
    chk("rst2_instr", instr, 0);
    chk("rst2_req_valid", imem.req_valid, 0);
    redirect_valid = 1'b0; imem.req_ready = 1'b0; instr_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    imem.rsp_valid = 1'b0;
    #1;
    chk("rst2_stale_instr_valid", instr_valid, 0);
    chk("rst2_stale_req_valid", imem.req_valid, 1);
    chk("rst2_stale_instr", instr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
